// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
// Shared helpers for the SRAM round-robin arbiter and the other shared-resource
// blocks that reuse rr_arbiter.
//   DEF_DATA_W / DEF_ADDR_W : default wrapper data / row-address widths
//   clog2_min1()            : ceil(log2(n)), never less than 1, so index and
//                             pointer fields stay legal for n = 1 or 2 and for
//                             non-power-of-two counts.
// The command record (sram_cmd_t) depends on the instance widths, so it is
// declared inside sram_rr_arbiter next to its parameters.
// ---------------------------------------------------------------------------
package sram_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 7;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < n) begin
                r = k + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Generic N-way round-robin arbiter. The winner is the first eligible requester
// found while scanning upward from the pointer, modulo N. The pointer moves to
// winner+1 only when the grant is actually taken (accept).
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   req        : request vector
//   mask       : 1 = requester not eligible this cycle (skipped, not stalled)
//   accept     : the current grant was consumed this cycle
//   gnt        : one-hot grant (all zero when nothing is eligible)
//   gnt_idx    : binary index of the granted requester
// ---------------------------------------------------------------------------
module rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N-1:0]             req,
    input  logic [N-1:0]             mask,
    input  logic                     accept,
    output logic [N-1:0]             gnt,
    output logic [clog2_min1(N)-1:0] gnt_idx
);

    localparam int               PTR_W = clog2_min1(N);
    localparam logic [N-1:0]     ONE   = N'(1);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(N - 1);

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;
    logic [N-1:0]     elig;

    assign elig = req & ~mask;

    // Scan from the farthest position back toward ptr so the last hit,
    // which is the closest one to ptr, ends up owning the grant.
    always_comb begin : pick
        int           idx;
        logic [N-1:0] elig_rot;
        gnt      = '0;
        gnt_idx  = '0;
        idx      = 0;
        elig_rot = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx      = (int'(ptr_reg) + k) % N;
            elig_rot = elig >> idx;
            if (elig_rot[0]) begin
                gnt     = ONE << idx;
                gnt_idx = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (accept) begin
            ptr_next = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/sram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// sram_rr_arbiter
// Sole master of one sram_wrapper port, shared round-robin by N_REQ requesters.
// Accepted commands are registered onto the wrapper pins one cycle later; read
// issuer IDs go into an in-order FIFO so returning rd_data is steered back to
// the requester that asked for it.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_val/req_wr        : per-requester command valid / write(1) or read(0)
//   req_addr/req_wdata    : packed per-requester row address / write data
//   req_rdy               : one-hot grant; accept = req_val[i] & req_rdy[i]
//   rsp_val/rsp_data      : one-hot read-data valid / shared read data
//   mem_en,rd_req,wr_req,
//   address,wr_data_in    : registered command to the wrapper
//   rd_data_val/rd_data   : read return from the wrapper
//   err_unexp_rsp         : sticky, read data arrived with no read outstanding
// ---------------------------------------------------------------------------
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RD_OUTST = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_val,
    input  logic [N_REQ-1:0]          req_wr,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_rdy,
    output logic [N_REQ-1:0]          rsp_val,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      mem_en,
    output logic                      rd_req,
    output logic                      wr_req,
    output logic [ADDR_W-1:0]         address,
    output logic [DATA_W-1:0]         wr_data_in,
    input  logic                      rd_data_val,
    input  logic [DATA_W-1:0]         rd_data,
    output logic                      err_unexp_rsp
);

    localparam int ID_W  = clog2_min1(N_REQ);
    localparam int FP_W  = clog2_min1(RD_OUTST);
    localparam int CNT_W = clog2_min1(RD_OUTST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_OUTST);
    localparam logic [FP_W-1:0]  FP_LAST = FP_W'(RD_OUTST - 1);

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [ID_W-1:0]   id;
    } sram_cmd_t;

    logic [ADDR_W-1:0] addr_arr  [N_REQ];
    logic [DATA_W-1:0] wdata_arr [N_REQ];
    logic [N_REQ-1:0]  rd_mask;
    logic [N_REQ-1:0]  gnt;
    logic [ID_W-1:0]   win_id;
    sram_cmd_t         win_cmd;
    logic              accept;
    logic              rd_full;

    // Command register
    logic              mem_en_reg;
    logic              rd_req_reg;
    logic              wr_req_reg;
    logic [ADDR_W-1:0] address_reg;
    logic [DATA_W-1:0] wr_data_reg;

    // Read-ID FIFO
    logic [ID_W-1:0]   id_mem [RD_OUTST];
    logic [FP_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [FP_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              push, pop, fifo_empty;
    logic [ID_W-1:0]   fifo_head;
    logic              err_reg;

    function automatic logic [FP_W-1:0] fp_inc(input logic [FP_W-1:0] p);
        return (p == FP_LAST) ? '0 : p + 1'b1;
    endfunction

    // A full FIFO only blocks reads; writes keep flowing so a read-heavy
    // requester cannot starve a writer.
    assign rd_full = (cnt_reg == CNT_MAX);

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
            assign rd_mask[gi]   = rd_full & ~req_wr[gi];
            assign rsp_val[gi]   = pop & (fifo_head == ID_W'(gi));
        end
    endgenerate

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_val),
        .mask    (rd_mask),
        .accept  (accept),
        .gnt     (gnt),
        .gnt_idx (win_id)
    );

    // Grants are suppressed while reset is asserted so no requester sees an
    // accept that the cleared datapath will never carry out.
    assign req_rdy = gnt & {N_REQ{rst_n}};
    assign accept  = |req_rdy;

    assign win_cmd.wr    = req_wr[win_id];
    assign win_cmd.addr  = addr_arr[win_id];
    assign win_cmd.wdata = wdata_arr[win_id];
    assign win_cmd.id    = win_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en_reg  <= 1'b0;
            rd_req_reg  <= 1'b0;
            wr_req_reg  <= 1'b0;
            address_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            mem_en_reg <= accept;
            rd_req_reg <= accept & ~win_cmd.wr;
            wr_req_reg <= accept & win_cmd.wr;
            if (accept) begin
                address_reg <= win_cmd.addr;
                wr_data_reg <= win_cmd.wdata;
            end
        end
    end

    assign push       = accept & ~win_cmd.wr;
    assign fifo_empty = (cnt_reg == '0);
    assign pop        = rd_data_val & ~fifo_empty;
    assign fifo_head  = id_mem[rd_ptr_reg];

    always_comb begin
        wr_ptr_next = push ? fp_inc(wr_ptr_reg) : wr_ptr_reg;
        rd_ptr_next = pop  ? fp_inc(rd_ptr_reg) : rd_ptr_reg;
        cnt_next    = cnt_reg;
        if (push && !pop) begin
            cnt_next = cnt_reg + 1'b1;
        end else if (pop && !push) begin
            cnt_next = cnt_reg - 1'b1;
        end
    end

    // ID storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr_reg] <= win_cmd.id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
            err_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            cnt_reg    <= cnt_next;
            err_reg    <= err_reg | (rd_data_val & fifo_empty);
        end
    end

    assign rsp_data      = rd_data;
    assign mem_en        = mem_en_reg;
    assign rd_req        = rd_req_reg;
    assign wr_req        = wr_req_reg;
    assign address       = address_reg;
    assign wr_data_in    = wr_data_reg;
    assign err_unexp_rsp = err_reg;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_rr_arbiter
// Drives sram_rr_arbiter (3 requesters, 2 reads outstanding) against a simple
// SRAM wrapper model with adjustable return delay. Expected behaviour comes
// from a queue-based reference: round-robin scan over the requesters, a queue
// of outstanding reads (issuer, expected data, accept cycle) and a reference
// memory updated in accept order.
// ---------------------------------------------------------------------------
module tb_sram_rr_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 7;
    localparam int RO = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_val, req_wr, req_rdy, rsp_val;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [DW-1:0]     rsp_data, wr_data_in, rd_data;
    logic              mem_en, rd_req, wr_req, rd_data_val, err_unexp_rsp;
    logic [AW-1:0]     address;

    always #5 clk = ~clk;

    sram_rr_arbiter #(
        .N_REQ    (N),
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .RD_OUTST (RO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_val       (req_val),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_rdy       (req_rdy),
        .rsp_val       (rsp_val),
        .rsp_data      (rsp_data),
        .mem_en        (mem_en),
        .rd_req        (rd_req),
        .wr_req        (wr_req),
        .address       (address),
        .wr_data_in    (wr_data_in),
        .rd_data_val   (rd_data_val),
        .rd_data       (rd_data),
        .err_unexp_rsp (err_unexp_rsp)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [DW-1:0] sram    [1<<AW];
    logic [DW-1:0] ref_mem [1<<AW];

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            acc;
    } rd_t;
    rd_t pend_q[$];

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } wrsp_t;
    wrsp_t wrap_q[$];

    int            ptr = 0;
    bit            exp_cmd_val = 0;
    bit            exp_cmd_wr  = 0;
    logic [AW-1:0] exp_addr  = '0;
    logic [DW-1:0] exp_wdata = '0;
    bit            exp_err   = 0;
    int            wrap_delay = 0;
    bit            stray = 0;

    logic [N-1:0]  s_val, s_wr;
    logic [AW-1:0] s_addr  [N];
    logic [DW-1:0] s_wdata [N];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic set_idle();
        s_val = '0;
        s_wr  = '0;
        for (int i = 0; i < N; i++) begin
            s_addr[i]  = '0;
            s_wdata[i] = '0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_req_rdy"}, 64'(req_rdy), 64'(0));
        check_val({tag, "_rsp_val"}, 64'(rsp_val), 64'(0));
        check_val({tag, "_mem_en"},  64'(mem_en),  64'(0));
        check_val({tag, "_rd_req"},  64'(rd_req),  64'(0));
        check_val({tag, "_wr_req"},  64'(wr_req),  64'(0));
        check_val({tag, "_address"}, 64'(address), 64'(0));
        check_val({tag, "_wdata"},   64'(wr_data_in), 64'(0));
        check_val({tag, "_err"},     64'(err_unexp_rsp), 64'(0));
    endtask

    // One clock of activity: check registered outputs, run the wrapper model,
    // drive this cycle's requests, check the combinational outputs, and
    // advance the reference model as of the coming rising edge.
    task automatic do_cycle();
        int           win;
        logic [N-1:0] exp_gnt;
        @(negedge clk);
        cyc++;
        check_val("mem_en",     64'(mem_en), 64'(exp_cmd_val));
        check_val("rd_req",     64'(rd_req), 64'(exp_cmd_val & ~exp_cmd_wr));
        check_val("wr_req",     64'(wr_req), 64'(exp_cmd_val & exp_cmd_wr));
        check_val("address",    64'(address), 64'(exp_addr));
        check_val("wr_data_in", 64'(wr_data_in), 64'(exp_wdata));
        check_val("err_flag",   64'(err_unexp_rsp), 64'(exp_err));

        if (mem_en === 1'b1 && wr_req === 1'b1) sram[address] = wr_data_in;
        if (mem_en === 1'b1 && rd_req === 1'b1) wrap_q.push_back('{sram[address], cyc + 1 + wrap_delay});

        rd_data_val = 1'b0;
        rd_data     = $urandom;
        if (stray) begin
            rd_data_val = 1'b1;
            stray       = 0;
        end else if (wrap_q.size() > 0 && wrap_q[0].due <= cyc) begin
            rd_data_val = 1'b1;
            rd_data     = wrap_q[0].data;
            void'(wrap_q.pop_front());
        end

        req_val = s_val;
        req_wr  = s_wr;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = s_addr[i];
            req_wdata[i*DW +: DW] = s_wdata[i];
        end
        #1;

        win = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (win < 0 && s_val[i] && (s_wr[i] || pend_q.size() < RO)) win = i;
        end
        exp_gnt = (win < 0) ? '0 : (N'(1) << win);
        check_val("req_rdy", 64'(req_rdy), 64'(exp_gnt));

        if (rd_data_val) begin
            if (pend_q.size() > 0) begin
                check_val("rsp_val",    64'(rsp_val), 64'(N'(1) << pend_q[0].id));
                check_val("rsp_data",   64'(rsp_data), 64'(pend_q[0].data));
                check_val("rd_latency", 64'(cyc - pend_q[0].acc), 64'(2 + wrap_delay));
                void'(pend_q.pop_front());
            end else begin
                check_val("rsp_val_stray", 64'(rsp_val), 64'(0));
                exp_err = 1;
            end
        end else begin
            check_val("rsp_val_idle", 64'(rsp_val), 64'(0));
        end

        exp_cmd_val = (win >= 0);
        if (win >= 0) begin
            exp_cmd_wr = s_wr[win];
            exp_addr   = s_addr[win];
            exp_wdata  = s_wdata[win];
            if (s_wr[win]) begin
                ref_mem[s_addr[win]] = s_wdata[win];
                $display("cyc %0d grant req%0d WR addr=%0d data=%h", cyc, win, s_addr[win], s_wdata[win]);
            end else begin
                pend_q.push_back('{win, ref_mem[s_addr[win]], cyc});
                $display("cyc %0d grant req%0d RD addr=%0d exp=%h", cyc, win, s_addr[win], ref_mem[s_addr[win]]);
            end
            ptr = (win + 1) % N;
        end
    endtask

    task automatic drain(input string tag);
        set_idle();
        for (int t = 0; t < 40; t++) begin
            if (pend_q.size() == 0 && wrap_q.size() == 0 && !exp_cmd_val) break;
            do_cycle();
        end
        do_cycle();
        check_val({tag, "_drained"}, 64'(pend_q.size()), 64'(0));
    endtask

    task automatic rd_cmd(input int r, input int a);
        s_val[r] = 1'b1; s_wr[r] = 1'b0; s_addr[r] = AW'(a);
    endtask

    task automatic wr_cmd(input int r, input int a, input logic [DW-1:0] d);
        s_val[r] = 1'b1; s_wr[r] = 1'b1; s_addr[r] = AW'(a); s_wdata[r] = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            sram[a]    = $urandom;
            ref_mem[a] = sram[a];
        end
        set_idle();
        rst_n       = 1'b0;
        req_val     = 3'b011;
        req_wr      = '0;
        req_addr    = '0;
        req_wdata   = '0;
        rd_data_val = 1'b0;
        rd_data     = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        req_val = '0;
        rst_n   = 1'b1;

        // Single read from requester 0
        set_idle(); rd_cmd(0, 5); do_cycle();
        drain("single_rd");

        // Move the pointer back to 0, then contend with writes from 0 and 1
        set_idle(); wr_cmd(2, 20, 32'h2222_0000); do_cycle();
        for (int c = 0; c < 4; c++) begin
            set_idle();
            wr_cmd(0, 30 + c, $urandom);
            wr_cmd(1, 40 + c, $urandom);
            do_cycle();
        end
        drain("contend");

        // Read throttle with a slow wrapper; writes from req1 must still pass
        wrap_delay = 3;
        for (int c = 0; c < 7; c++) begin
            set_idle();
            rd_cmd(0, 30 + c);
            if (c >= 2 && c <= 4) wr_cmd(1, 50 + c, $urandom);
            do_cycle();
        end
        drain("throttle");
        wrap_delay = 0;

        // Write then read of the same row
        set_idle(); wr_cmd(1, 9, 32'hDEAD_BEEF); do_cycle();
        set_idle(); rd_cmd(0, 9); do_cycle();
        drain("wr_then_rd");

        // Steady alternating reads
        for (int c = 0; c < 10; c++) begin
            set_idle();
            rd_cmd(c % 2, 40 + c);
            do_cycle();
        end
        drain("steady");

        // Randomised traffic in segments with differing wrapper delay
        for (int seg = 0; seg < 4; seg++) begin
            wrap_delay = (seg == 3) ? 0 : seg;
            for (int c = 0; c < 250; c++) begin
                set_idle();
                for (int r = 0; r < N; r++) begin
                    if ($urandom_range(0, 99) < 60) begin
                        if ($urandom_range(0, 1) == 1) wr_cmd(r, $urandom_range(0, 15), $urandom);
                        else rd_cmd(r, $urandom_range(0, 15));
                    end
                end
                do_cycle();
            end
            drain("random");
        end
        wrap_delay = 0;

        // Reset with two reads in flight, then a stray return
        wrap_delay = 3;
        set_idle(); rd_cmd(0, 3); do_cycle();
        set_idle(); rd_cmd(1, 4); do_cycle();
        check_val("inflight", 64'(pend_q.size()), 64'(2));
        set_idle(); rd_cmd(0, 6);
        @(negedge clk);
        req_val     = 3'b001;
        req_wr      = 3'b000;
        rd_data_val = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        pend_q.delete();
        wrap_q.delete();
        ptr = 0; exp_cmd_val = 0; exp_cmd_wr = 0;
        exp_addr = '0; exp_wdata = '0; exp_err = 0;
        wrap_delay = 0;
        repeat (2) @(negedge clk);
        rd_data_val = 1'b0;
        req_val     = '0;
        rst_n       = 1'b1;
        set_idle(); do_cycle();
        stray = 1; do_cycle();
        set_idle(); do_cycle(); do_cycle();
        check_val("err_sticky", 64'(err_unexp_rsp), 64'(1));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
